// File: rtl/rst_seq_pll.sv
// Reset sequencer: PLL reset pulse, filtered lock, staggered release of NUM_RST channels.
// Define RST_SEQ_LOCK_TIMEOUT_EN to retry the PLL after LOCK_TIMEOUT cycles without lock.
module rst_seq_pll #(
  parameter int NUM_RST        = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 16,
  parameter int STAGE_DLY      = 8,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_locked,
  input  logic               i_sw_rst,
  input  logic               i_clr_status,
  output logic               o_pll_rst,
  output logic [NUM_RST-1:0] o_rst,
  output logic               o_busy,
  output logic               o_lock_lost,
  output logic [7:0]         o_retry_cnt
);

  localparam int PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int SW = $clog2(STAGE_DLY + 1);

  if (NUM_RST < 1 || SYNC_STAGES < 2 || PLL_RST_CYCLES < 1 || LOCK_FILTER < 1 ||
      STAGE_DLY < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("rst_seq_pll: illegal parameter value");
  end

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [PW-1:0]          pll_cnt;
  logic [FW-1:0]          filt_cnt;
  logic [SW-1:0]          stage_cnt;
  logic [NUM_RST-1:0]     rst_next;

  assign lock_s = sync[SYNC_STAGES-1];
  // Shifting the reset vector left clears exactly the next channel, keeping the low-order run contiguous.
  assign rst_next = o_rst << 1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], i_locked};
  end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                to_cnt <= '0;
    else if (state != WAIT_LOCK) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 1'b1;
  end
`else
  assign o_retry_cnt = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= PLL_RST;
      o_pll_rst   <= 1'b1;
      o_rst       <= '1;
      o_busy      <= 1'b1;
      o_lock_lost <= 1'b0;
      pll_cnt     <= '0;
      filt_cnt    <= '0;
      stage_cnt   <= '0;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
      o_retry_cnt <= '0;
`endif
    end else begin
      // A lock-loss set further down overrides this clear.
      if (i_clr_status) o_lock_lost <= 1'b0;
      case (state)
        PLL_RST: begin
          if (pll_cnt == PW'(PLL_RST_CYCLES - 1)) begin
            state     <= WAIT_LOCK;
            o_pll_rst <= 1'b0;
            pll_cnt   <= '0;
            filt_cnt  <= '0;
          end else begin
            pll_cnt <= pll_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (i_sw_rst) begin
            state <= HOLD;
          end else if (lock_s && filt_cnt == FW'(LOCK_FILTER - 1)) begin
            state     <= RELEASE;
            o_rst     <= rst_next;
            stage_cnt <= '0;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
          end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
            state     <= PLL_RST;
            o_pll_rst <= 1'b1;
            pll_cnt   <= '0;
            if (o_retry_cnt != 8'hFF) o_retry_cnt <= o_retry_cnt + 8'd1;
`endif
          end else begin
            filt_cnt <= lock_s ? filt_cnt + 1'b1 : '0;
          end
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            o_rst       <= '1;
            o_busy      <= 1'b1;
            o_lock_lost <= 1'b1;
            filt_cnt    <= '0;
          end else if (i_sw_rst) begin
            state  <= HOLD;
            o_rst  <= '1;
            o_busy <= 1'b1;
          end else if (state == RELEASE) begin
            if (o_rst == '0) begin
              state  <= RUN;
              o_busy <= 1'b0;
            end else if (stage_cnt == SW'(STAGE_DLY - 1)) begin
              o_rst     <= rst_next;
              stage_cnt <= '0;
              if (rst_next == '0) begin
                state  <= RUN;
                o_busy <= 1'b0;
              end
            end else begin
              stage_cnt <= stage_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!i_sw_rst) begin
            state    <= WAIT_LOCK;
            filt_cnt <= '0;
          end
        end
        default: state <= PLL_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_pll.sv
// Self-checking bench for rst_seq_pll: directed vector table, async reset, randomized run vs reference model.
module tb_rst_seq_pll;
  localparam int NUM_RST = 2;
  localparam int SYNC    = 2;
  localparam int PLLC    = 16;
  localparam int FILT    = 16;
  localparam int SDLY    = 8;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam int LTO   = 100;
  localparam bit TO_EN = 1'b1;
`else
  localparam int LTO   = 65535;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0, locked = 1'b0, sw_rst = 1'b0, clr = 1'b0;
  logic pll_rst, busy, lost;
  logic [NUM_RST-1:0] rst;
  logic [7:0] retry;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rst_seq_pll #(
    .NUM_RST(NUM_RST), .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PLLC),
    .LOCK_FILTER(FILT), .STAGE_DLY(SDLY), .LOCK_TIMEOUT(LTO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked), .i_sw_rst(sw_rst),
    .i_clr_status(clr), .o_pll_rst(pll_rst), .o_rst(rst), .o_busy(busy),
    .o_lock_lost(lost), .o_retry_cnt(retry)
  );

  // Reference model: cycles left in PLL reset, number of channels released (-1 = waiting for lock).
  int m_pll_left, m_released, m_consec, m_waitc, m_since, m_retry;
  bit m_hold, m_lost;
  logic [SYNC-1:0] m_hist;

  function void model_reset();
    m_pll_left = PLLC; m_released = -1; m_consec = 0; m_waitc = 0; m_since = 0;
    m_retry = 0; m_hold = 1'b0; m_lost = 1'b0; m_hist = '0;
  endfunction

  function void model_step(bit lk, bit sw, bit cl);
    bit ls, lost_set;
    ls = m_hist[SYNC-1];
    lost_set = 1'b0;
    if (m_pll_left > 0) begin
      m_pll_left--;
      if (m_pll_left == 0) begin m_released = -1; m_consec = 0; m_waitc = 0; end
    end else if (m_hold) begin
      if (!sw) begin m_hold = 1'b0; m_released = -1; m_consec = 0; m_waitc = 0; end
    end else if (m_released < 0) begin
      if (sw) m_hold = 1'b1;
      else if (ls && m_consec + 1 == FILT) begin m_released = 1; m_since = 0; end
      else if (TO_EN && m_waitc + 1 == LTO) begin
        m_pll_left = PLLC;
        if (m_retry < 255) m_retry++;
      end else begin
        m_consec = ls ? m_consec + 1 : 0;
        m_waitc++;
      end
    end else begin
      if (!ls) begin m_released = -1; m_consec = 0; m_waitc = 0; lost_set = 1'b1; end
      else if (sw) begin m_hold = 1'b1; m_released = -1; end
      else begin
        m_since++;
        if (m_released < NUM_RST && m_since == SDLY) begin m_released++; m_since = 0; end
      end
    end
    m_lost = lost_set ? 1'b1 : (cl ? 1'b0 : m_lost);
    m_hist = {m_hist[SYNC-2:0], lk};
  endfunction

  function logic [NUM_RST-1:0] m_rst();
    logic [NUM_RST-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_RST; i++) if (i < m_released) v[i] = 1'b0;
    return v;
  endfunction

  function bit m_busy();
    return !(m_released == NUM_RST && (NUM_RST > 1 || m_since >= 1));
  endfunction

  task automatic check_model(input string name);
    logic [NUM_RST-1:0] er;
    bit ep, eb;
    er = m_rst(); ep = (m_pll_left > 0); eb = m_busy();
    checks++;
    if (pll_rst !== ep || rst !== er || busy !== eb || lost !== m_lost || retry !== 8'(m_retry)) begin
      errors++;
      $display("FAIL %s @%0t: got pll=%b rst=%b busy=%b lost=%b retry=%0d, expected pll=%b rst=%b busy=%b lost=%b retry=%0d",
               name, $time, pll_rst, rst, busy, lost, retry, ep, er, eb, m_lost, m_retry);
    end
  endtask

  task automatic check_vals(input string name, input bit ep, input logic [NUM_RST-1:0] er,
                            input bit eb, input bit el);
    checks++;
    if (pll_rst !== ep || rst !== er || busy !== eb || lost !== el) begin
      errors++;
      $display("FAIL %s @%0t: got pll=%b rst=%b busy=%b lost=%b, expected pll=%b rst=%b busy=%b lost=%b",
               name, $time, pll_rst, rst, busy, lost, ep, er, eb, el);
    end
  endtask

  task automatic step(input bit lk, input bit sw, input bit cl, input string name);
    locked = lk; sw_rst = sw; clr = cl;
    @(posedge clk);
    model_step(lk, sw, cl);
    #1;
    check_model(name);
  endtask

  typedef struct {
    int cyc;
    bit lk, sw, cl;
    bit e_pll;
    logic [NUM_RST-1:0] e_rst;
    bit e_busy, e_lost;
  } vec_t;
  vec_t tab[$];

  initial begin
    tab.push_back('{16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0}); // PLL reset ends at edge 16
    tab.push_back('{15, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0});
    tab.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0}); // first channel
    tab.push_back('{ 7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0});
    tab.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}); // second channel, RUN
    tab.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
    tab.push_back('{ 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}); // lock loss in flight
    tab.push_back('{ 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{ 2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0}); // clear flag, relock
    tab.push_back('{15, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0});
    tab.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0});
    tab.push_back('{ 2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0}); // sw reset in RELEASE
    tab.push_back('{ 3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0});
    tab.push_back('{16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0});
    tab.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0});
    tab.push_back('{ 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
    tab.push_back('{ 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}); // loss with clear same edge
    tab.push_back('{ 1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{ 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1}); // glitchy lock
    tab.push_back('{ 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{ 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{17, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1});
    tab.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1});
    tab.push_back('{ 8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0});

    model_reset();
    locked = 1'b1;
    repeat (2) @(negedge clk);
    check_vals("reset", 1'b1, '1, 1'b1, 1'b0);
    checks++;
    if (retry !== 8'd0) begin
      errors++;
      $display("FAIL reset_retry: got %0d, expected 0", retry);
    end
    rst_n = 1'b1;

    foreach (tab[i]) begin
      for (int c = 0; c < tab[i].cyc; c++) step(tab[i].lk, tab[i].sw, tab[i].cl, "tab_model");
      check_vals($sformatf("tab[%0d]", i), tab[i].e_pll, tab[i].e_rst, tab[i].e_busy, tab[i].e_lost);
    end

    // Async reset asserted mid-RELEASE, between clock edges.
    step(1'b1, 1'b1, 1'b0, "hold");
    for (int c = 0; c < 17; c++) step(1'b1, 1'b0, 1'b0, "relock");
    check_vals("pre_async", 1'b0, 2'b10, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, "release_mid");
    #3 rst_n = 1'b0;
    #1;
    check_vals("async_rst", 1'b1, '1, 1'b1, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized segments of lock level and software reset, per-cycle status clear.
    for (int s = 0; s < 200; s++) begin
      int len;
      bit lk, sw;
      len = $urandom_range(1, 40);
      lk = ($urandom_range(0, 9) < 7);
      sw = ($urandom_range(0, 9) == 0);
      for (int c = 0; c < len; c++) step(lk, sw, ($urandom_range(0, 19) == 0), "random");
    end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    for (int c = 0; c < 30000; c++) step(1'b0, 1'b0, 1'b0, "timeout");
    checks++;
    if (retry !== 8'd255) begin
      errors++;
      $display("FAIL retry_sat: got %0d, expected 255", retry);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
